accel_spi_target: RTL and testbench

ACCEL_SPI_TARGET -- requirements
Module: accel_spi_target

---
 rtl/accel_spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/accel_spi_target.sv | 217 +++++++++++++++++++++
 tb/tb_accel_spi_target.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_spi_pkg.sv
// Shared constants and types for the accelerometer-style SPI register target.
package accel_spi_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h0A;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [7:0] DEFAULT_ID = 8'hAD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    WR_DATA = 3'd3,
    RD_DATA = 3'd4,
    IGNORE  = 3'd5
  } state_e;

  // Register addresses wrap from 0x3F back to 0x00 during bursts.
  function automatic logic [5:0] addr_inc(input logic [5:0] a);
    return a + 6'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;

  // Next value of the chain: shift the raw pin in at the bottom.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = i_d;
  end

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign o_q    = sync_q[STAGES-1];
  assign o_rise = sync_q[STAGES-1] & ~prev_q;
  assign o_fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/accel_spi_target.sv
// SPI mode-0 target exposing a 64x8 register file. Command 0x0A writes and
// 0x0B reads a burst starting at a 6-bit address; register 0 is a read-only
// ID. A local update port can also write the registers.
module accel_spi_target
  import accel_spi_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = DEFAULT_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  input  logic       i_upd_valid,
  input  logic [5:0] i_upd_addr,
  input  logic [7:0] i_upd_data,
  output logic       o_wr_valid,
  output logic [5:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .i_d(i_sclk),
    .o_q(sclk_s), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rstn(rstn), .i_d(i_cs_n),
    .o_q(cs_s), .o_rise(cs_rise), .o_fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rstn(rstn), .i_d(i_mosi),
    .o_q(mosi_s), .o_rise(mosi_rise), .o_fall(mosi_fall)
  );

  // Abort uses the synchronized CS level (covers the rising edge); the
  // remaining edge pulses have no use in this block.
  logic unused_edges;
  assign unused_edges = ^{cs_rise, mosi_rise, mosi_fall, sclk_s};

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [5:0]             addr_q, addr_d;
  logic                   is_read_q, is_read_d;
  logic [7:0]             tx_q, tx_d;
  logic                   miso_q, miso_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [5:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   armed_q, armed_d;
  logic [SYNC_STAGES:0]   settle_q;
  logic [7:0]             regs_q [64];

  logic [7:0] byte_in;
  logic       byte_done;
  logic       spi_we;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;

  // The byte that completes on this rising edge, including the new bit.
  assign byte_in   = {shift_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  // The address byte itself selects the first read location; later bytes
  // use the running burst address.
  assign rd_addr = (state_q == ADDR) ? byte_in[5:0] : addr_q;
  assign rd_data = (rd_addr == 6'd0) ? ID_VALUE : regs_q[rd_addr];

  // Count clocks after reset until the CS synchronizer holds the real pin
  // level, so a CS already low at reset release is not seen as a new frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      settle_q <= '0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Transaction FSM, bit/byte assembly, TX shifting and write reporting.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    is_read_d  = is_read_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    spi_we     = 1'b0;
    armed_d    = armed_q | (settle_q[SYNC_STAGES] & cs_s);

    if (state_q == IDLE) begin
      if (cs_fall && armed_q) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        shift_d   = 8'h00;
        tx_d      = 8'h00;
        miso_d    = 1'b0;
      end
    end else if (cs_s) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      miso_d    = 1'b0;
    end else begin
      if (sclk_rise) begin
        shift_d   = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (sclk_fall && (state_q == RD_DATA)) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (byte_done) begin
        case (state_q)
          CMD: begin
            if (byte_in == CMD_WRITE) begin
              state_d   = ADDR;
              is_read_d = 1'b0;
            end else if (byte_in == CMD_READ) begin
              state_d   = ADDR;
              is_read_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
          ADDR: begin
            if (is_read_q) begin
              state_d = RD_DATA;
              tx_d    = rd_data;
              addr_d  = addr_inc(byte_in[5:0]);
            end else begin
              state_d = WR_DATA;
              addr_d  = byte_in[5:0];
            end
          end
          WR_DATA: begin
            spi_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = byte_in;
            addr_d     = addr_inc(addr_q);
          end
          RD_DATA: begin
            tx_d   = rd_data;
            addr_d = addr_inc(addr_q);
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      addr_q     <= 6'd0;
      is_read_q  <= 1'b0;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 6'd0;
      wr_data_q  <= 8'h00;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      is_read_q  <= is_read_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      armed_q    <= armed_d;
    end
  end

  // Register file: local updates first, SPI write last so it wins a collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      if (i_upd_valid && (i_upd_addr != 6'd0)) begin
        regs_q[i_upd_addr] <= i_upd_data;
      end
      if (spi_we && (addr_q != 6'd0)) begin
        regs_q[addr_q] <= byte_in;
      end
    end
  end

  assign o_miso     = (state_q == RD_DATA) ? miso_q : 1'b0;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_accel_spi_target.sv
// Directed, table-driven bench for accel_spi_target using an SPI mode-0
// initiator model running at 1/16 of the system clock.
module tb_accel_spi_target;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_sclk, i_cs_n, i_mosi;
  logic       o_miso;
  logic       i_upd_valid;
  logic [5:0] i_upd_addr;
  logic [7:0] i_upd_data;
  logic       o_wr_valid;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_busy;

  int compared   = 0;
  int mismatched = 0;

  logic [5:0] pulseAddr[$];
  logic [7:0] pulseData[$];

  typedef struct packed {
    logic [2:0]  nBytes;
    logic [31:0] mosi;
    logic [31:0] miso;
    logic [1:0]  nPulses;
    logic [5:0]  a0;
    logic [7:0]  d0;
    logic [5:0]  a1;
    logic [7:0]  d1;
  } vec_t;

  vec_t vecs [6];

  accel_spi_target dut (
    .clk(clk), .rstn(rstn),
    .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi), .o_miso(o_miso),
    .i_upd_valid(i_upd_valid), .i_upd_addr(i_upd_addr), .i_upd_data(i_upd_data),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Record every write pulse seen by the initiator side.
  always @(negedge clk) begin
    if (rstn && o_wr_valid) begin
      pulseAddr.push_back(o_wr_addr);
      pulseData.push_back(o_wr_data);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearPulses();
    pulseAddr.delete();
    pulseData.delete();
  endtask

  task automatic csLow();
    i_cs_n = 1'b0;
    waitClk(HALF);
  endtask

  task automatic csHigh();
    waitClk(HALF);
    i_cs_n = 1'b1;
    waitClk(2 * HALF);
  endtask

  // Shift nBits of tx out MSB first, capturing MISO just before each rising
  // edge. With collide set, the local update port targets 0x10 with 0x55
  // around the eighth rising edge until the write pulse shows up.
  task automatic spiBits(input logic [7:0] tx, input int nBits, input bit collide,
                         output logic [7:0] rx);
    int n;
    rx = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      i_mosi = tx[7-i];
      waitClk(HALF);
      rx = {rx[6:0], o_miso};
      if (collide && i == 7) begin
        i_upd_valid = 1'b1;
        i_upd_addr  = 6'h10;
        i_upd_data  = 8'h55;
        i_sclk = 1'b1;
        n = 0;
        while (!o_wr_valid && n < 4 * HALF) begin
          waitClk(1);
          n++;
        end
        checkOutput("collision write pulse seen", {31'b0, o_wr_valid}, 32'd1);
        i_upd_valid = 1'b0;
        waitClk((n < HALF) ? HALF - n : 1);
      end else begin
        i_sclk = 1'b1;
        waitClk(HALF);
      end
      i_sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [31:0] mosi, input int n, output logic [31:0] miso);
    logic [7:0] rx;
    miso = 32'h0;
    csLow();
    for (int b = 0; b < n; b++) begin
      spiBits(mosi[31-8*b -: 8], 8, 1'b0, rx);
      miso[31-8*b -: 8] = rx;
    end
    csHigh();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] miso;
    clearPulses();
    xfer(v.mosi, int'(v.nBytes), miso);
    checkOutput($sformatf("vec%0d miso bytes", idx), miso, v.miso);
    checkOutput($sformatf("vec%0d pulse count", idx), pulseAddr.size(), {30'b0, v.nPulses});
    for (int p = 0; p < pulseAddr.size() && p < int'(v.nPulses); p++) begin
      checkOutput($sformatf("vec%0d pulse%0d addr", idx, p), {26'b0, pulseAddr[p]},
                  {26'b0, (p == 0) ? v.a0 : v.a1});
      checkOutput($sformatf("vec%0d pulse%0d data", idx, p), {24'b0, pulseData[p]},
                  {24'b0, (p == 0) ? v.d0 : v.d1});
    end
  endtask

  initial begin
    logic [31:0] miso;
    logic [7:0]  rx;

    vecs[0] = '{nBytes:3'd3, mosi:32'h0B000000, miso:32'h0000AD00, nPulses:2'd0,
                a0:6'h00, d0:8'h00, a1:6'h00, d1:8'h00};
    vecs[1] = '{nBytes:3'd4, mosi:32'h0A2C1357, miso:32'h00000000, nPulses:2'd2,
                a0:6'h2C, d0:8'h13, a1:6'h2D, d1:8'h57};
    vecs[2] = '{nBytes:3'd4, mosi:32'h0B2C0000, miso:32'h00001357, nPulses:2'd0,
                a0:6'h00, d0:8'h00, a1:6'h00, d1:8'h00};
    vecs[3] = '{nBytes:3'd4, mosi:32'h55112233, miso:32'h00000000, nPulses:2'd0,
                a0:6'h00, d0:8'h00, a1:6'h00, d1:8'h00};
    vecs[4] = '{nBytes:3'd3, mosi:32'h0B110000, miso:32'h00000000, nPulses:2'd0,
                a0:6'h00, d0:8'h00, a1:6'h00, d1:8'h00};
    vecs[5] = '{nBytes:3'd4, mosi:32'h0B2C0000, miso:32'h00001357, nPulses:2'd0,
                a0:6'h00, d0:8'h00, a1:6'h00, d1:8'h00};

    rstn = 1'b0;
    i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
    i_upd_valid = 1'b0; i_upd_addr = 6'h00; i_upd_data = 8'h00;
    waitClk(3);
    checkOutput("outputs during reset",
                {9'b0, o_miso, o_wr_valid, o_busy, 6'b0, o_wr_addr, o_wr_data}, 32'h0);
    rstn = 1'b1;
    waitClk(6);
    checkOutput("outputs after reset",
                {9'b0, o_miso, o_wr_valid, o_busy, 6'b0, o_wr_addr, o_wr_data}, 32'h0);

    $display("[TB] busy tracks chip select");
    csLow();
    checkOutput("busy with CS low", {31'b0, o_busy}, 32'd1);
    csHigh();
    checkOutput("busy with CS high", {31'b0, o_busy}, 32'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] local update then wrapping read");
    i_upd_valid = 1'b1; i_upd_addr = 6'h3F; i_upd_data = 8'h5A;
    waitClk(1);
    i_upd_addr = 6'h00; i_upd_data = 8'h11;
    waitClk(1);
    i_upd_valid = 1'b0;
    waitClk(2);
    xfer(32'h0B3F0000, 4, miso);
    checkOutput("read 0x3F burst with wrap", miso, 32'h00005AAD);

    $display("[TB] abort in the middle of a write data byte");
    clearPulses();
    csLow();
    spiBits(8'h0A, 8, 1'b0, rx);
    spiBits(8'h20, 8, 1'b0, rx);
    spiBits(8'h77, 4, 1'b0, rx);
    csHigh();
    checkOutput("abort pulse count", pulseAddr.size(), 32'd0);
    xfer(32'h0B200000, 3, miso);
    checkOutput("read 0x20 after abort", miso, 32'h00000000);
    xfer(32'h0B2C0000, 3, miso);
    checkOutput("read 0x2C after abort", miso, 32'h00001300);

    $display("[TB] SPI write colliding with local update");
    clearPulses();
    csLow();
    spiBits(8'h0A, 8, 1'b0, rx);
    spiBits(8'h10, 8, 1'b0, rx);
    spiBits(8'hAA, 8, 1'b1, rx);
    csHigh();
    checkOutput("collision pulse count", pulseAddr.size(), 32'd1);
    if (pulseAddr.size() > 0) begin
      checkOutput("collision pulse addr", {26'b0, pulseAddr[0]}, 32'h10);
      checkOutput("collision pulse data", {24'b0, pulseData[0]}, 32'hAA);
    end
    xfer(32'h0B100000, 3, miso);
    checkOutput("read 0x10 after collision", miso, 32'h0000AA00);

    $display("[TB] reset released with CS already low");
    i_cs_n = 1'b0;
    rstn = 1'b0;
    waitClk(3);
    checkOutput("outputs during reset with CS low",
                {9'b0, o_miso, o_wr_valid, o_busy, 6'b0, o_wr_addr, o_wr_data}, 32'h0);
    rstn = 1'b1;
    waitClk(HALF);
    clearPulses();
    spiBits(8'h0A, 8, 1'b0, rx);
    spiBits(8'h05, 8, 1'b0, rx);
    spiBits(8'h99, 8, 1'b0, rx);
    checkOutput("busy for stale CS frame", {31'b0, o_busy}, 32'd0);
    csHigh();
    checkOutput("stale frame pulse count", pulseAddr.size(), 32'd0);
    xfer(32'h0B050000, 3, miso);
    checkOutput("read 0x05 after stale frame", miso, 32'h00000000);
    xfer(32'h0B2C0000, 3, miso);
    checkOutput("read 0x2C cleared by reset", miso, 32'h00000000);
    xfer(32'h0B000000, 3, miso);
    checkOutput("read ID after reset", miso, 32'h0000AD00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
